// File: rtl/mem_arbiter_pkg.sv
// Shared bus definitions for mem_arbiter and future clients of the core memory port:
// state and port encodings, default widths and the tie-break helper.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int WDOG_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_e;

  // On a tie the port that did not win last time gets the bus.
  function automatic port_id_e pick_port(input logic i_req, input logic d_req,
                                         input port_id_e last);
    port_id_e gnt;
    if (i_req && d_req) begin
      gnt = (last == PORT_I) ? PORT_D : PORT_I;
    end else if (d_req) begin
      gnt = PORT_D;
    end else begin
      gnt = PORT_I;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arbiter_bus_watchdog.sv
// Saturating 8-bit busy-cycle counter; expire_o flags the TIMEOUT-th enabled cycle.
module bus_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [WDOG_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between fetch (I) and load/store (D) with a
// registered grant, alternating tie priority and a watchdog that ends hung accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ready,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err,
  output logic                busy
);

  arb_state_e state_q;
  port_id_e   last_gnt_q;
  port_id_e   gnt_s;
  logic       in_busy_s;
  logic       in_idle_s;
  logic       wd_expire_s;

  assign in_busy_s = (state_q != ST_IDLE);
  assign in_idle_s = !in_busy_s;
  assign gnt_s     = pick_port(i_valid, d_valid, last_gnt_q);

  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (in_idle_s),
    .en_i     (in_busy_s),
    .expire_o (wd_expire_s)
  );

  // Grant FSM: a busy state ends on completion, requester flush or watchdog expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= PORT_I;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid || d_valid) begin
            state_q    <= (gnt_s == PORT_D) ? ST_BUSY_D : ST_BUSY_I;
            last_gnt_q <= gnt_s;
          end
        end
        ST_BUSY_I: begin
          if (!i_valid || mem_ready || wd_expire_s) state_q <= ST_IDLE;
        end
        ST_BUSY_D: begin
          if (!d_valid || mem_ready || wd_expire_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output muxes; completion is same-cycle, and reset forces everything low.
  always_comb begin
    i_ready   = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    bus_err   = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_BUSY_I: begin
          busy      = 1'b1;
          mem_valid = i_valid;
          mem_addr  = i_addr;
          if (i_valid && mem_ready) begin
            i_ready = 1'b1;
            i_rdata = mem_rdata;
          end else if (i_valid && wd_expire_s) begin
            i_ready = 1'b1;
            bus_err = 1'b1;
          end else begin
            i_ready = 1'b0;
          end
        end
        ST_BUSY_D: begin
          busy      = 1'b1;
          mem_valid = d_valid;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_wstrb = d_wstrb;
          if (d_valid && mem_ready) begin
            d_ready = 1'b1;
            d_rdata = mem_rdata;
          end else if (d_valid && wd_expire_s) begin
            d_ready = 1'b1;
            bus_err = 1'b1;
          end else begin
            d_ready = 1'b0;
          end
        end
        default: busy = 1'b0;
      endcase
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (TIMEOUT=4 and TIMEOUT=0) share stimulus
// and are checked every cycle against an ownership/age model, plus literal spot checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, d_valid, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;

  logic        i_ready_w   [2];
  logic [31:0] i_rdata_w   [2];
  logic        d_ready_w   [2];
  logic [31:0] d_rdata_w   [2];
  logic        mem_valid_w [2];
  logic [31:0] mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic [3:0]  mem_wstrb_w [2];
  logic        bus_err_w   [2];
  logic        busy_w      [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_w[0]), .i_rdata(i_rdata_w[0]),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready_w[0]), .d_rdata(d_rdata_w[0]),
    .mem_valid(mem_valid_w[0]), .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
    .mem_wstrb(mem_wstrb_w[0]), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_err(bus_err_w[0]), .busy(busy_w[0])
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u_dut_nowd (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_w[1]), .i_rdata(i_rdata_w[1]),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready_w[1]), .d_rdata(d_rdata_w[1]),
    .mem_valid(mem_valid_w[1]), .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
    .mem_wstrb(mem_wstrb_w[1]), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .bus_err(bus_err_w[1]), .busy(busy_w[1])
  );

  // Model state: owner 0 = nobody, 1 = fetch, 2 = load/store; age = busy cycle number from 1.
  typedef struct {
    int owner;
    int age;
    int last;
  } mdl_t;

  mdl_t cur [2];
  mdl_t nx  [2];

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic model_eval(input int k, output logic [136:0] e, output mdl_t n);
    logic ir, dr, mv, be, bz, xv;
    logic [31:0] ird, drd, ma, mw;
    logic [3:0] ms;
    ir = 1'b0; dr = 1'b0; mv = 1'b0; be = 1'b0; bz = 1'b0; xv = 1'b0;
    ird = 32'd0; drd = 32'd0; ma = 32'd0; mw = 32'd0; ms = 4'd0;
    n = cur[k];
    if (rst) begin
      n.owner = 0; n.age = 0; n.last = 0;
    end else if (cur[k].owner == 0) begin
      if (i_valid && d_valid) n.owner = (cur[k].last == 0) ? 2 : 1;
      else if (d_valid) n.owner = 2;
      else if (i_valid) n.owner = 1;
      if (n.owner != 0) n.last = n.owner - 1;
      n.age = 1;
    end else begin
      bz = 1'b1;
      xv = (cur[k].owner == 1) ? i_valid : d_valid;
      mv = xv;
      ma = (cur[k].owner == 1) ? i_addr : d_addr;
      mw = (cur[k].owner == 2) ? d_wdata : 32'd0;
      ms = (cur[k].owner == 2) ? d_wstrb : 4'd0;
      if (!xv) begin
        n.owner = 0;
      end else if (mem_ready) begin
        if (cur[k].owner == 1) begin ir = 1'b1; ird = mem_rdata; end
        else begin dr = 1'b1; drd = mem_rdata; end
        n.owner = 0;
      end else if (tmo(k) != 0 && cur[k].age == tmo(k)) begin
        if (cur[k].owner == 1) ir = 1'b1;
        else dr = 1'b1;
        be = 1'b1;
        n.owner = 0;
      end else begin
        n.age = cur[k].age + 1;
      end
    end
    e = {ir, ird, dr, drd, mv, ma, mw, ms, be, bz};
  endtask

  // Per-cycle compare of every output of both instances against the model.
  always @(negedge clk) begin
    logic [136:0] ev, gv;
    mdl_t nn;
    for (int k = 0; k < 2; k++) begin
      model_eval(k, ev, nn);
      gv = {i_ready_w[k], i_rdata_w[k], d_ready_w[k], d_rdata_w[k], mem_valid_w[k],
            mem_addr_w[k], mem_wdata_w[k], mem_wstrb_w[k], bus_err_w[k], busy_w[k]};
      n_vec++;
      if (gv !== ev) begin
        n_err++;
        $display("FAIL outputs dut%0d t=%0t got=%h exp=%h", k, $time, gv, ev);
      end
      nx[k] = nn;
    end
  end

  // Advance the model at the clock edge.
  always @(posedge clk) begin
    cur[0] <= nx[0];
    cur[1] <= nx[1];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] order [4];
    int ng;
    for (int k = 0; k < 2; k++) begin
      cur[k] = '{0, 0, 0};
      nx[k]  = '{0, 0, 0};
    end
    for (int j = 0; j < 4; j++) order[j] = 32'd0;
    rst = 1'b1; i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_wstrb = 4'd0; mem_rdata = 32'd0;
    cyc(); cyc();
    #2 chk("reset_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("reset_mem_valid", {31'd0, mem_valid_w[0]}, 32'd0);

    // Single fetch.
    cyc(); rst = 1'b0; i_valid = 1'b1; i_addr = 32'h100;
    #2 chk("fetch_idle_mem_valid", {31'd0, mem_valid_w[0]}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    #2 chk("fetch_mem_valid", {31'd0, mem_valid_w[0]}, 32'd1);
    chk("fetch_mem_addr", mem_addr_w[0], 32'h100);
    chk("fetch_i_ready", {31'd0, i_ready_w[0]}, 32'd1);
    chk("fetch_i_rdata", i_rdata_w[0], 32'hDEADBEEF);
    cyc(); i_valid = 1'b0; mem_ready = 1'b0;
    #2 chk("fetch_busy_after", {31'd0, busy_w[0]}, 32'd0);
    chk("fetch_i_ready_after", {31'd0, i_ready_w[0]}, 32'd0);

    // Contention after reset: expect D, I, D, I.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    i_valid = 1'b1; i_addr = 32'h40;
    d_valid = 1'b1; d_addr = 32'h80; d_wstrb = 4'h3; d_wdata = 32'h55;
    mem_ready = 1'b1; mem_rdata = 32'h11;
    ng = 0;
    for (int c = 0; c < 8; c++) begin
      #2;
      if (mem_valid_w[0]) begin
        if (ng < 4) order[ng] = mem_addr_w[0];
        if (mem_addr_w[0] == 32'h40) chk("contend_i_wstrb", {28'd0, mem_wstrb_w[0]}, 32'd0);
        ng++;
      end
      cyc();
    end
    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0; d_wstrb = 4'd0;
    chk("contend_count", ng, 32'd4);
    chk("contend_gnt0", order[0], 32'h80);
    chk("contend_gnt1", order[1], 32'h40);
    chk("contend_gnt2", order[2], 32'h80);
    chk("contend_gnt3", order[3], 32'h40);

    // Store pass-through.
    cyc(); d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_wstrb = 4'hF;
    cyc();
    #2 chk("store_mem_valid", {31'd0, mem_valid_w[0]}, 32'd1);
    chk("store_mem_addr", mem_addr_w[0], 32'h2000);
    chk("store_mem_wdata", mem_wdata_w[0], 32'h12345678);
    chk("store_mem_wstrb", {28'd0, mem_wstrb_w[0]}, 32'hF);
    chk("store_d_ready_wait", {31'd0, d_ready_w[0]}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    #2 chk("store_d_ready", {31'd0, d_ready_w[0]}, 32'd1);
    cyc(); d_valid = 1'b0; mem_ready = 1'b0; d_wstrb = 4'd0;

    // Flush abort with a pending fetch behind it.
    cyc(); d_valid = 1'b1; d_addr = 32'h300;
    cyc(); i_valid = 1'b1; i_addr = 32'h500;
    cyc(); d_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77;
    #2 chk("flush_d_ready", {31'd0, d_ready_w[0]}, 32'd0);
    chk("flush_mem_valid", {31'd0, mem_valid_w[0]}, 32'd0);
    cyc(); mem_ready = 1'b0;
    #2 chk("flush_idle_busy", {31'd0, busy_w[0]}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h5151;
    #2 chk("flush_i_grant_addr", mem_addr_w[0], 32'h500);
    chk("flush_i_ready", {31'd0, i_ready_w[0]}, 32'd1);
    cyc(); i_valid = 1'b0; mem_ready = 1'b0;

    // Watchdog: TIMEOUT=4 terminates in busy cycle 4; TIMEOUT=0 never does.
    cyc(); i_valid = 1'b1; i_addr = 32'h600; mem_rdata = 32'hAAAA5555;
    for (int w = 1; w <= 4; w++) begin
      cyc();
      #2;
      if (w < 4) begin
        chk("wdog_no_err", {31'd0, bus_err_w[0]}, 32'd0);
      end else begin
        chk("wdog_err", {31'd0, bus_err_w[0]}, 32'd1);
        chk("wdog_i_ready", {31'd0, i_ready_w[0]}, 32'd1);
        chk("wdog_i_rdata", i_rdata_w[0], 32'd0);
      end
    end
    cyc();
    #2 chk("wdog_idle_after", {31'd0, busy_w[0]}, 32'd0);
    for (int w = 0; w < 16; w++) begin
      cyc();
      #2 chk("nowdog_busy", {31'd0, busy_w[1]}, 32'd1);
    end

    // Reset mid-access, then a tie goes to D.
    cyc(); rst = 1'b1; d_valid = 1'b1; d_addr = 32'h900;
    #2 chk("rst_busy", {31'd0, busy_w[1]}, 32'd0);
    cyc(); rst = 1'b0;
    #2 chk("post_rst_busy", {31'd0, busy_w[1]}, 32'd0);
    chk("post_rst_mem_valid", {31'd0, mem_valid_w[1]}, 32'd0);
    chk("post_rst_i_ready", {31'd0, i_ready_w[1]}, 32'd0);
    cyc(); mem_ready = 1'b1; mem_rdata = 32'h3C3C;
    #2 chk("post_rst_gnt_d", mem_addr_w[1], 32'h900);
    chk("post_rst_gnt_d_wd", mem_addr_w[0], 32'h900);
    chk("post_rst_d_ready", {31'd0, d_ready_w[1]}, 32'd1);
    cyc(); i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    cyc(); cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
